// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax pipeline: Q6.10 format, saturation limits,
// lane slicing and the max-subtract FSM states.
package softmax_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 10;

    localparam logic signed [DATA_W-1:0] SAT_MIN = 16'sh8000;
    localparam logic signed [DATA_W-1:0] SAT_MAX = 16'sh7FFF;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Low bit index of a lane inside a flattened N*DATA_W bus.
    function automatic int lane_lo(input int lane);
        return lane * DATA_W;
    endfunction

    // x - m computed at DATA_W+1 bits, clamped back into DATA_W bits.
    function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] x,
                                                  input logic [DATA_W-1:0] m);
        logic [DATA_W:0] diff;
        diff = {x[DATA_W-1], x} - {m[DATA_W-1], m};
        if (diff[DATA_W] != diff[DATA_W-1]) begin
            return diff[DATA_W] ? SAT_MIN : SAT_MAX;
        end
        return diff[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/row_buffer.sv
// Simple dual-port RAM holding {mask, data} beats of one row.
// Registered read; contents are never reset.
module row_buffer #(
    parameter int WIDTH = 136,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        // Read data holds when not enabled, so a stalled output stays stable.
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/max_subtract_buffer.sv
// Buffers a row of N-lane beats while tracking the row maximum, then replays
// every beat with that maximum subtracted (saturated, non-positive Q6.10).
module max_subtract_buffer
    import softmax_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                valid_MAX_in,
    input  logic [DATA_W-1:0]   MAX_in,
    input  logic [N-1:0]        valid_bypass_in,
    input  logic [N*DATA_W-1:0] bypass_in,
    input  logic                last_in,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        out_mask,
    output logic [N*DATA_W-1:0] out_flat,
    output logic                out_last,
    output logic [DATA_W-1:0]   row_max,
    output logic                overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = N * DATA_W + N;

    state_t            r_state;
    logic [CW-1:0]     r_wr_cnt;
    logic [CW-1:0]     r_rd_ptr;
    logic [DATA_W-1:0] r_run_max;
    logic [DATA_W-1:0] r_row_max;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_out_last;
    logic              r_overflow;

    logic              w_accept;
    logic              w_fill;
    logic              w_term;
    logic [DATA_W-1:0] w_max_next;
    logic              w_hs;
    logic              w_load;
    logic              w_more;
    logic              w_rd_en;
    logic [WW-1:0]     w_rd_data;
    logic [N-1:0]      w_rd_mask;

    assign w_accept   = en & valid_MAX_in & r_in_ready & (r_state == ACCUM);
    assign w_fill     = (r_wr_cnt == CW'(DEPTH - 1));
    assign w_term     = w_accept & (last_in | w_fill);
    assign w_max_next = ((r_wr_cnt == '0) || ($signed(MAX_in) > $signed(r_run_max)))
                        ? MAX_in : r_run_max;

    // The output slot refills whenever it is empty or being consumed this cycle.
    assign w_hs    = en & r_out_valid & out_ready;
    assign w_load  = en & (r_state == DRAIN) & (~r_out_valid | out_ready);
    assign w_more  = (r_rd_ptr < r_wr_cnt);
    assign w_rd_en = w_load & w_more;

    row_buffer #(
        .WIDTH (WW),
        .DEPTH (DEPTH)
    ) u_row_buffer (
        .clk       (clk),
        .i_wr_en   (w_accept),
        .i_wr_addr (r_wr_cnt[AW-1:0]),
        .i_wr_data ({valid_bypass_in, bypass_in}),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ACCUM;
            r_wr_cnt    <= '0;
            r_rd_ptr    <= '0;
            r_run_max   <= '0;
            r_row_max   <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (en) begin
            case (r_state)
                ACCUM: begin
                    r_in_ready <= ~w_term;
                    if (w_accept) begin
                        r_wr_cnt  <= r_wr_cnt + CW'(1);
                        r_run_max <= w_max_next;
                    end
                    if (w_term) begin
                        r_state   <= DRAIN;
                        r_row_max <= w_max_next;
                        r_rd_ptr  <= '0;
                        if (!last_in) begin
                            r_overflow <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_load) begin
                        if (w_more) begin
                            r_rd_ptr    <= r_rd_ptr + CW'(1);
                            r_out_valid <= 1'b1;
                            r_out_last  <= (r_rd_ptr == r_wr_cnt - CW'(1));
                        end else begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end
                    end
                    if (w_hs && r_out_last) begin
                        r_state     <= ACCUM;
                        r_wr_cnt    <= '0;
                        r_rd_ptr    <= '0;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign w_rd_mask = w_rd_data[WW-1 -: N];

    // Lane data comes straight off the RAM read register; gating by out_valid
    // keeps the outputs at zero whenever no beat is presented.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            assign out_flat[lane_lo(gi) +: DATA_W] =
                (r_out_valid && w_rd_mask[gi])
                ? sat_sub(w_rd_data[lane_lo(gi) +: DATA_W], r_row_max)
                : '0;
        end
    endgenerate

    assign out_mask  = r_out_valid ? w_rd_mask : '0;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign row_max   = r_row_max;
    assign overflow  = r_overflow;

endmodule
